// File: rtl/imem_pkg.sv
// imem_pkg: shared loader states and instruction-memory defaults
package imem_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE} state_t;
  localparam int DEPTH_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-clock instruction RAM, one write port, one registered read port
module imem_ram #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH] = '{default: '0};
  // Only the read register resets; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= rst ? '0 : mem[raddr];
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader filling the instruction RAM, with fetch read port
module imem_loader import imem_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       index,
  output logic [31:0]       InstrReg,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [1:0] byte_idx;
  logic [ADDR_W:0] remaining;
  logic [ADDR_W:0] length;
  logic [31:0] word;
  logic unused_index;
  assign unused_index = ^index[31:ADDR_W];
  assign rx_ready = state == LEN || state == DATA;
  assign cpu_hold = state != IDLE;
  assign load_done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      byte_idx <= '0;
      remaining <= '0;
      length <= '0;
      word <= '0;
      load_err <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LEN;
          load_err <= 1'b0;
          addr <= '0;
          byte_idx <= '0;
        end
        LEN: if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
            load_err <= 1'b1;
            state <= IDLE;
          end else begin
            remaining <= rx_data[ADDR_W:0];
            length <= rx_data[ADDR_W:0];
            addr <= '0;
            state <= DATA;
          end
        end
        DATA: if (rx_valid) begin
          word <= {word[23:0], rx_data};
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'(BYTES_PER_WORD - 1)) state <= WRITE;
        end
        WRITE: begin
          addr <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          state <= remaining == (ADDR_W+1)'(1) ? DONE : DATA;
        end
        DONE: begin
          words_loaded <= length;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst(reset),
    .we(state == WRITE),
    .waddr(addr),
    .wdata(word),
    .raddr(index[ADDR_W-1:0]),
    .rdata(InstrReg)
  );
endmodule
